// File: rtl/routing_table_mp.sv
// routing_table_mp: N-context, N-port next-hop table with per-context active/shadow banks
// Sits between the flit router's destination decode and the output-port arbiter.
// Optional feature macro: ROUTING_TABLE_PARITY_EN (even parity per entry, adds parity_err_out).
// Ports:
//   clock, reset_n                        system clock, asynchronous active-low reset
//   enable                                lookup pipeline advance (0 holds lookup outputs)
//   ram_config_in[_valid]                 16-bit daisy-chained config word in
//   ram_config_out[_valid]                registered forwarded config word out
//   lk_valid_in, ccid_in, dest_in         per-port lookup request (context id, destination)
//   lk_valid_out, ccid_out, nexthop_out,  per-port result, 1 cycle after the request
//   hit_out                               1 = context loaded and entry good
//   parity_err_out                        per-port parity mismatch pulse (parity build only)
//   ctx_loaded                            per-context image valid flags
//   cfg_busy                              config FSM not idle
module routing_table_mp #(
  parameter int NUM_PORTS = 2,
  parameter int LOG_CTX = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int NH_WIDTH = 9,
  parameter logic [5:0] TABLE_ID = 6'd0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [15:0]                     ram_config_in,
  input  logic                            ram_config_in_valid,
  output logic [15:0]                     ram_config_out,
  output logic                            ram_config_out_valid,
  input  logic [NUM_PORTS-1:0]            lk_valid_in,
  input  logic [NUM_PORTS*LOG_CTX-1:0]    ccid_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] dest_in,
  output logic [NUM_PORTS-1:0]            lk_valid_out,
  output logic [NUM_PORTS*LOG_CTX-1:0]    ccid_out,
  output logic [NUM_PORTS*NH_WIDTH-1:0]   nexthop_out,
  output logic [NUM_PORTS-1:0]            hit_out,
`ifdef ROUTING_TABLE_PARITY_EN
  output logic [NUM_PORTS-1:0]            parity_err_out,
`endif
  output logic [2**LOG_CTX-1:0]           ctx_loaded,
  output logic                            cfg_busy
);
  localparam int NCTX = 2**LOG_CTX;
  localparam int MAW = 1 + LOG_CTX + ADDR_WIDTH;
`ifdef ROUTING_TABLE_PARITY_EN
  localparam int EW = NH_WIDTH + 1;
`else
  localparam int EW = NH_WIDTH;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, FWD, SWAP} state_t;
  state_t state, state_nx;
  logic [LOG_CTX-1:0] ctx;
  logic [ADDR_WIDTH-1:0] idx, cnt;
  logic [NCTX-1:0] active;
  logic is_hdr, hdr_mine, fwd, wr_en, do_swap;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] mem [0:2**MAW-1];
  logic [NUM_PORTS-1:0] hit_nx, perr_nx;
  logic [NUM_PORTS*NH_WIDTH-1:0] nh_nx;
  assign is_hdr = ram_config_in_valid & ram_config_in[15];
  assign hdr_mine = is_hdr & (ram_config_in[13:8] == TABLE_ID);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = hdr_mine ? LOAD : is_hdr ? FWD : IDLE;
      LOAD: state_nx = (ram_config_in_valid && &idx) ? SWAP : LOAD;
      FWD:  state_nx = (ram_config_in_valid && &cnt) ? IDLE : FWD;
      SWAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    fwd = ram_config_in_valid & ((state == IDLE & ~hdr_mine) | state == FWD);
    wr_en = ram_config_in_valid & (state == LOAD);
    do_swap = state == SWAP;
    cfg_busy = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ctx <= '0;
      idx <= '0;
      cnt <= '0;
      active <= '0;
      ctx_loaded <= '0;
      ram_config_out <= '0;
      ram_config_out_valid <= 1'b0;
    end else begin
      if (state == IDLE && hdr_mine) ctx <= ram_config_in[LOG_CTX-1:0];
      if (state == IDLE && hdr_mine) idx <= '0;
      else if (wr_en) idx <= idx + 1'b1;
      if (state == IDLE && is_hdr) cnt <= '0;
      else if (state == FWD && ram_config_in_valid) cnt <= cnt + 1'b1;
      if (do_swap) begin
        active[ctx] <= ~active[ctx];
        ctx_loaded[ctx] <= 1'b1;
      end
      ram_config_out_valid <= fwd;
      if (fwd) ram_config_out <= ram_config_in;
    end
`ifdef ROUTING_TABLE_PARITY_EN
  assign wr_data = {^ram_config_in[NH_WIDTH-1:0], ram_config_in[NH_WIDTH-1:0]};
`else
  assign wr_data = ram_config_in[NH_WIDTH-1:0];
`endif
  // Writes always target the shadow bank, so they never collide with live lookups.
  always_ff @(posedge clock)
    if (wr_en) mem[{~active[ctx], ctx, idx}] <= wr_data;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lk
    logic [LOG_CTX-1:0] c;
    logic [EW-1:0] e;
    assign c = ccid_in[p*LOG_CTX +: LOG_CTX];
    assign e = mem[{active[c], c, dest_in[p*ADDR_WIDTH +: ADDR_WIDTH]}];
`ifdef ROUTING_TABLE_PARITY_EN
    // Only loaded contexts hold written data, so only they can report a parity error.
    assign perr_nx[p] = lk_valid_in[p] & ctx_loaded[c] & ^e;
`else
    assign perr_nx[p] = 1'b0;
`endif
    assign hit_nx[p] = lk_valid_in[p] & ctx_loaded[c] & ~perr_nx[p];
    assign nh_nx[p*NH_WIDTH +: NH_WIDTH] = hit_nx[p] ? e[NH_WIDTH-1:0] : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      lk_valid_out <= '0;
      ccid_out <= '0;
      nexthop_out <= '0;
      hit_out <= '0;
`ifdef ROUTING_TABLE_PARITY_EN
      parity_err_out <= '0;
`endif
    end else if (enable) begin
      lk_valid_out <= lk_valid_in;
      ccid_out <= ccid_in;
      nexthop_out <= nh_nx;
      hit_out <= hit_nx;
`ifdef ROUTING_TABLE_PARITY_EN
      parity_err_out <= perr_nx;
`endif
    end
`ifndef ROUTING_TABLE_PARITY_EN
  logic unused_perr;
  assign unused_perr = ^perr_nx;
`endif
endmodule

// File: tb/tb_routing_table_mp.sv
// tb_routing_table_mp: directed + randomized bench for routing_table_mp against an image-level model
module tb_routing_table_mp;
  localparam int P = 2, LC = 3, AW = 8, NW = 9, NC = 8, D = 256;
  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b1;
  logic [15:0] cfg_in = '0, cfg_out;
  logic cfg_v = 1'b0, cfg_out_v, cfg_busy;
  logic [P-1:0] lk_valid_in = '0, lk_valid_out, hit_out;
  logic [P*LC-1:0] ccid_in = '0, ccid_out;
  logic [P*AW-1:0] dest_in = '0;
  logic [P*NW-1:0] nexthop_out;
  logic [NC-1:0] ctx_loaded;
  int total = 0, bad = 0;
  logic [NW-1:0] live [NC][D];
  logic [NW-1:0] shadow [D];
  bit loaded [NC];
  logic e_v [P], e_hit [P];
  logic [LC-1:0] e_c [P];
  logic [NW-1:0] e_nh [P];

  routing_table_mp dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .ram_config_in(cfg_in), .ram_config_in_valid(cfg_v),
    .ram_config_out(cfg_out), .ram_config_out_valid(cfg_out_v),
    .lk_valid_in(lk_valid_in), .ccid_in(ccid_in), .dest_in(dest_in),
    .lk_valid_out(lk_valid_out), .ccid_out(ccid_out), .nexthop_out(nexthop_out),
    .hit_out(hit_out), .ctx_loaded(ctx_loaded), .cfg_busy(cfg_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [NC-1:0] model_loaded();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = loaded[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) loaded[c] = 1'b0;
    for (int p = 0; p < P; p++) begin
      e_v[p] = 1'b0; e_hit[p] = 1'b0; e_c[p] = '0; e_nh[p] = '0;
    end
  endtask

  task automatic drive_port(input int p, input bit v, input int c, input int d);
    lk_valid_in[p] = v;
    ccid_in[p*LC +: LC] = LC'(c);
    dest_in[p*AW +: AW] = AW'(d);
  endtask

  task automatic rand_lookups();
    for (int p = 0; p < P; p++)
      drive_port(p, ($urandom % 4) != 0, int'($urandom_range(0, NC-1)), int'($urandom_range(0, D-1)));
  endtask

  // Expected result of the request currently on the inputs, from the image model before the edge.
  task automatic set_exp();
    if (enable)
      for (int p = 0; p < P; p++) begin
        logic [LC-1:0] c;
        logic [AW-1:0] d;
        c = ccid_in[p*LC +: LC];
        d = dest_in[p*AW +: AW];
        e_v[p] = lk_valid_in[p];
        e_c[p] = c;
        e_hit[p] = lk_valid_in[p] & loaded[c];
        e_nh[p] = e_hit[p] ? live[c][d] : '0;
      end
  endtask

  task automatic chk_lk();
    for (int p = 0; p < P; p++) begin
      chk($sformatf("lk_valid_out[%0d]", p), lk_valid_out[p], e_v[p]);
      chk($sformatf("ccid_out[%0d]", p), ccid_out[p*LC +: LC], e_c[p]);
      chk($sformatf("hit_out[%0d]", p), hit_out[p], e_hit[p]);
      chk($sformatf("nexthop_out[%0d]", p), nexthop_out[p*NW +: NW], e_nh[p]);
    end
  endtask

  task automatic lk_cycle();
    set_exp();
    tick();
    chk_lk();
  endtask

  // Header plus 256 data words; base < 0 selects random data. look keeps port0 on (c, 0x20).
  task automatic cfg_seq(input logic [5:0] id, input int c, input int base, input bit look);
    bit mine;
    int n;
    logic [15:0] w;
    mine = (id == 6'd0);
    n = mine ? D + 2 : D + 1;
    if (look) drive_port(0, 1'b1, c, 'h20);
    for (int k = 0; k < n; k++) begin
      if (k == 0) w = 16'h8000 | {2'b00, id, 8'h00} | 16'(c);
      else if (k <= D) w = (base < 0) ? 16'($urandom) : 16'(k - 1 + base);
      else w = '0;
      cfg_in = w;
      cfg_v = (k <= D);
      if (mine && k >= 1 && k <= D) shadow[k-1] = w[NW-1:0];
      set_exp();
      tick();
      if (mine && k == D + 1) begin
        for (int i = 0; i < D; i++) live[c][i] = shadow[i];
        loaded[c] = 1'b1;
      end
      chk("cfg_busy", cfg_busy, mine ? (k < D + 1) : (k < D));
      chk("cfg_out_valid", cfg_out_v, !mine);
      if (!mine) chk("cfg_out_data", cfg_out, w);
      chk("ctx_loaded", ctx_loaded, model_loaded());
      if (look) chk_lk();
    end
    cfg_v = 1'b0;
    cfg_in = '0;
    if (look) drive_port(0, 1'b0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    chk("rst_lk", {lk_valid_out, hit_out, nexthop_out, ccid_out}, '0);
    chk("rst_ctx_loaded", ctx_loaded, '0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_cfg_out", {cfg_out_v, cfg_out}, '0);
    reset_n = 1'b1;
    tick();
    // Lookup to an unloaded context misses.
    drive_port(0, 1'b1, 2, 'h10);
    lk_cycle();
    chk("unloaded_valid", lk_valid_out[0], 1'b1);
    chk("unloaded_hit", hit_out[0], 1'b0);
    drive_port(0, 1'b0, 0, 0);
    // First load of ctx 3 with i+5.
    cfg_seq(6'd0, 3, 5, 1'b0);
    chk("ctx3_loaded", ctx_loaded[3], 1'b1);
    drive_port(1, 1'b1, 3, 'h20);
    lk_cycle();
    chk("ctx3_nh_0x20", nexthop_out[NW +: NW], 9'h025);
    drive_port(1, 1'b0, 0, 0);
    // Reload ctx 3 with i+100 while port0 keeps looking up 0x20.
    cfg_seq(6'd0, 3, 100, 1'b1);
    drive_port(0, 1'b1, 3, 'h20);
    lk_cycle();
    chk("ctx3_reload_nh", nexthop_out[NW-1:0], 9'h084);
    // Second context with random data, then random traffic and same-address ports.
    cfg_seq(6'd0, 1, -1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rand_lookups();
      lk_cycle();
    end
    drive_port(0, 1'b1, 1, 'h7f);
    drive_port(1, 1'b1, 1, 'h7f);
    lk_cycle();
    // Foreign table id: everything forwarded, local image untouched.
    cfg_seq(6'd5, 1, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_lookups();
      lk_cycle();
    end
    // Reset during a load at word 100.
    drive_port(0, 1'b0, 0, 0);
    drive_port(1, 1'b0, 0, 0);
    cfg_in = 16'h8005;
    cfg_v = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      cfg_in = 16'(i);
      tick();
    end
    cfg_in = 16'd100;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_busy", cfg_busy, 1'b0);
    chk("rst_mid_out_valid", cfg_out_v, 1'b0);
    chk("rst_mid_loaded", ctx_loaded, '0);
    cfg_v = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("after_abort_loaded", ctx_loaded[5], 1'b0);
    chk("after_abort_busy", cfg_busy, 1'b0);
    cfg_seq(6'd0, 5, 7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_port(0, 1'b1, 5, int'($urandom_range(0, D-1)));
      lk_cycle();
    end
    drive_port(0, 1'b0, 0, 0);
    // Idle pass-through word, then async reset clears the forwarded valid immediately.
    cfg_in = 16'h1234;
    cfg_v = 1'b1;
    tick();
    cfg_v = 1'b0;
    chk("pass_valid", cfg_out_v, 1'b1);
    chk("pass_data", cfg_out, 16'h1234);
    chk("pass_busy", cfg_busy, 1'b0);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_out_valid", cfg_out_v, 1'b0);
    chk("async_out_data", cfg_out, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    // Enable hold: outputs freeze for 3 cycles while inputs keep changing.
    cfg_seq(6'd0, 3, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      enable = (i < 4 || i > 6);
      rand_lookups();
      lk_cycle();
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_lookups();
      lk_cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/routing_table_mp.md
Name: routing_table_mp

Overview:
- Parametrised successor to the single-image two-port routing table.
- N-context, N-port routing table with per-context double-buffered (active/shadow) banks, so one context can be reloaded while lookups continue against its live image.
- Config arrives on the 16-bit daisy-chained config bus. Words addressed to other tables are forwarded downstream.
- Sits between the flit router's destination decode and the output-port arbiter.

Parameters:
- NUM_PORTS, 2, number of independent lookup ports (1..8)
- LOG_CTX, 3, log2 number of contexts
- ADDR_WIDTH, 8, destination address width
- NH_WIDTH, 9, next-hop width (1..13)
- TABLE_ID, 0, 6-bit id this instance answers to on the config chain

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  lookup pipeline advance; 0 holds lookup output regs
- ram_config_in  in  16  config word
- ram_config_in_valid  in  1  config word valid
- ram_config_out  out  16  forwarded config word (registered)
- ram_config_out_valid  out  1  forwarded word valid
- lk_valid_in  in  NUM_PORTS  per-port lookup request
- ccid_in  in  NUM_PORTS*LOG_CTX  per-port context id, port p at [p*LOG_CTX +: LOG_CTX]
- dest_in  in  NUM_PORTS*ADDR_WIDTH  per-port destination
- lk_valid_out  out  NUM_PORTS  result valid
- ccid_out  out  NUM_PORTS*LOG_CTX  context id, aligned to the result
- nexthop_out  out  NUM_PORTS*NH_WIDTH  next hop
- hit_out  out  NUM_PORTS  1 = context loaded and entry good
- ctx_loaded  out  2**LOG_CTX  per-context "image valid" flags
- cfg_busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Storage: 2 banks x 2**LOG_CTX contexts x 2**ADDR_WIDTH entries of NH_WIDTH bits. Per-context active[ctx] bit selects the live bank.
- Lookup read address is {active[ccid], ccid, dest}. Config writes go to {~active[ctx], ctx, idx}, so reads and writes never touch the same word.
- Lookup latency is 1 cycle. When enable=1, each port registers valid, ccid, nexthop and hit. When enable=0, all lookup output regs hold.
- hit = valid_in & ctx_loaded[ccid]. If not hit, nexthop_out = 0.
- Header word: bit15=1, bits[13:8]=table id, bits[LOG_CTX-1:0]=ctx.
- Config FSM states: IDLE, LOAD, FWD, SWAP.
- IDLE:
  - header with id==TABLE_ID: latch ctx, idx=0, go to LOAD.
  - header with other id: forward it, cnt=0, go to FWD.
  - non-header valid word: forward it unchanged (chain pass-through).
- LOAD: each valid word writes bits[NH_WIDTH-1:0] to shadow[ctx][idx] and increments idx. Bit15 is ignored in LOAD. The write of idx = 2**ADDR_WIDTH-1 moves to SWAP. Nothing is forwarded while in LOAD.
- FWD: forward 2**ADDR_WIDTH data words, then return to IDLE.
- SWAP (1 cycle, ignores input): toggle active[ctx], set ctx_loaded[ctx]=1, go to IDLE. Upstream must not drive a valid word in this cycle.
- Lookups issued in the SWAP cycle read the old bank. Lookups from the next cycle read the new bank.
- Forwarding: ram_config_out <= ram_config_in, and ram_config_out_valid is asserted 1 cycle after the input word.
- cfg_busy = (state != IDLE).
- Reset (async, reset_n=0):
  - state=IDLE, all active=0, all ctx_loaded=0.
  - lk_valid_out=0, hit_out=0, ccid_out=0, nexthop_out=0.
  - ram_config_out=0, ram_config_out_valid=0.
  - Memory contents are not reset.
- Reset mid-LOAD aborts the load; the context stays unloaded.
- A reload of an already-loaded context keeps serving the old image until SWAP, and ctx_loaded stays 1 throughout.
- Lookups to different contexts on different ports in the same cycle are independent. Identical addresses on multiple ports are legal.

Optional Feature:
- Macro: ROUTING_TABLE_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit computed at write time.
  - each port has an extra output parity_err_out[NUM_PORTS], a 1-cycle pulse aligned with lk_valid_out, asserted on mismatch.
  - a mismatching lookup forces hit_out=0 and nexthop_out=0.
- When undefined: no parity storage, and the parity_err_out port is absent.

Test Plan:
- After reset, lookup port0 ctx=2 dest=0x10 -> next cycle lk_valid_out[0]=1, hit_out[0]=0, nexthop=0, ctx_loaded=0.
- Header 0x8003 (id 0, ctx 3), then 256 words with word i = i+5 -> SWAP, ctx_loaded[3]=1. Port1 ctx3 dest=0x20 -> nexthop=0x025, hit=1.
- Reload ctx3 with i+100 while port0 continuously looks up dest 0x20 -> returns 0x025 through the SWAP cycle, then 0x084 (=132) from the next cycle on.
- Header 0x8501 (id 5) plus 256 words -> all 257 forwarded with 1-cycle delay and identical data; the local table is unchanged and cfg_busy=1 throughout.
- reset_n low at load word 100 -> state IDLE, ctx_loaded unchanged-at-0 for that ctx, and ram_config_out_valid=0 immediately (async).
- enable=0 for 3 cycles during lookups -> outputs hold their last values; resuming with enable=1 continues the sequence with no lost or duplicated results.
